// File: rtl/set_scanner_pkg.sv
// Shared constants, mode encodings and FSM state type for the set scanner.
package set_scanner_pkg;
    localparam int COORD_SZ   = 4;
    localparam int GRID_MAX   = 8;
    localparam int CAND_SZ    = 8;
    localparam int MODE_SZ    = 2;
    localparam int COVERED_SZ = 3;

    // A only, A and B, A xor B, exactly two of A/B/C
    localparam logic [MODE_SZ-1:0] MODE1 = 2'd0;
    localparam logic [MODE_SZ-1:0] MODE2 = 2'd1;
    localparam logic [MODE_SZ-1:0] MODE3 = 2'd2;
    localparam logic [MODE_SZ-1:0] MODE4 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/set_scanner_circle_hit.sv
// Combinational point-in-circle test: covered when (x-cx)^2 + (y-cy)^2 <= r^2.
module circle_hit #(
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] cx,
    input  logic [COORD_W-1:0] cy,
    input  logic [COORD_W-1:0] r,
    output logic               covered
);
    logic [COORD_W:0]     dx, dy, ndx, ndy;
    logic [COORD_W-1:0]   adx, ady;
    logic [2*COORD_W-1:0] sqx, sqy, r2;
    logic [2*COORD_W:0]   d2;

    // Square the magnitudes; d2 carries one extra bit so far-off centres cannot wrap.
    always_comb begin
        dx  = {1'b0, x} - {1'b0, cx};
        dy  = {1'b0, y} - {1'b0, cy};
        ndx = -dx;
        ndy = -dy;
        adx = dx[COORD_W] ? ndx[COORD_W-1:0] : dx[COORD_W-1:0];
        ady = dy[COORD_W] ? ndy[COORD_W-1:0] : dy[COORD_W-1:0];
        sqx = {{COORD_W{1'b0}}, adx} * {{COORD_W{1'b0}}, adx};
        sqy = {{COORD_W{1'b0}}, ady} * {{COORD_W{1'b0}}, ady};
        r2  = {{COORD_W{1'b0}}, r} * {{COORD_W{1'b0}}, r};
        d2  = {1'b0, sqx} + {1'b0, sqy};
        covered = (d2 <= {1'b0, r2});
    end
endmodule

// File: rtl/set_scanner.sv
// Walks the lattice one point per clock, presents per-circle coverage to the
// external set-logic unit and counts the points it reports as hits.
module set_scanner
    import set_scanner_pkg::*;
#(
    parameter int GRID_N  = GRID_MAX,
    parameter int COORD_W = COORD_SZ
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [6*COORD_W-1:0]  central_i,
    input  logic [3*COORD_W-1:0]  radius_i,
    input  logic [MODE_SZ-1:0]    mode_i,
    output logic [COVERED_SZ-1:0] covered_o,
    output logic [MODE_SZ-1:0]    mode_o,
    input  logic                  hit_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [CAND_SZ-1:0]    candidate_o
);
    localparam int NPTS  = GRID_N * GRID_N;
    localparam int P_W   = $clog2(NPTS);
    localparam int CNT_W = $clog2(NPTS + 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(NPTS - 1);

    state_e                 state_d, state_q;
    logic [6*COORD_W-1:0]   central_d, central_q;
    logic [3*COORD_W-1:0]   radius_d, radius_q;
    logic [MODE_SZ-1:0]     mode_d, mode_q;
    logic [P_W-1:0]         p_d, p_q;
    logic [CNT_W-1:0]       count_d, count_q;
    logic [COVERED_SZ-1:0]  covered_d, covered_q;
    logic                   cov_vld_d, cov_vld_q;
    logic                   busy_d, busy_q;
    logic                   valid_d, valid_q;
    logic [CAND_SZ-1:0]     candidate_d, candidate_q;

    logic [COORD_W-1:0]     px, py;
    logic [COVERED_SZ-1:0]  cov;
    logic                   hit_eff;

    // x is the outer loop, y the inner; lattice coordinates start at 1.
    always_comb begin
        px = COORD_W'(int'(p_q) / GRID_N + 1);
        py = COORD_W'(int'(p_q) % GRID_N + 1);
    end

    for (genvar i = 0; i < 3; i++) begin : g_circ
        circle_hit #(.COORD_W(COORD_W)) u_circ (
            .x       (px),
            .y       (py),
            .cx      (central_q[(6-2*i)*COORD_W-1 -: COORD_W]),
            .cy      (central_q[(5-2*i)*COORD_W-1 -: COORD_W]),
            .r       (radius_q[(3-i)*COORD_W-1 -: COORD_W]),
            .covered (cov[2-i])
        );
    end

    // Gating keeps an undriven hit_i outside the scan window out of the count.
    assign hit_eff = cov_vld_q & hit_i;

    always_comb begin
        state_d     = state_q;
        central_d   = central_q;
        radius_d    = radius_q;
        mode_d      = mode_q;
        p_d         = p_q;
        count_d     = count_q;
        covered_d   = covered_q;
        cov_vld_d   = cov_vld_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        candidate_d = candidate_q;
        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    central_d = central_i;
                    radius_d  = radius_i;
                    mode_d    = mode_i;
                    busy_d    = 1'b1;
                    p_d       = '0;
                    count_d   = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                covered_d = cov;
                cov_vld_d = 1'b1;
                p_d       = p_q + 1'b1;
                count_d   = count_q + {{(CNT_W-1){1'b0}}, hit_eff};
                if (p_q == P_LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Last point's hit is still on hit_i; fold it straight into the result.
                candidate_d = CAND_SZ'(count_q) + {{(CAND_SZ-1){1'b0}}, hit_eff};
                valid_d     = 1'b1;
                cov_vld_d   = 1'b0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            central_q   <= '0;
            radius_q    <= '0;
            mode_q      <= '0;
            p_q         <= '0;
            count_q     <= '0;
            covered_q   <= '0;
            cov_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            candidate_q <= '0;
        end else begin
            state_q     <= state_d;
            central_q   <= central_d;
            radius_q    <= radius_d;
            mode_q      <= mode_d;
            p_q         <= p_d;
            count_q     <= count_d;
            covered_q   <= covered_d;
            cov_vld_q   <= cov_vld_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            candidate_q <= candidate_d;
        end
    end

    assign covered_o   = covered_q;
    assign mode_o      = mode_q;
    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign candidate_o = candidate_q;
endmodule
